// File: rtl/seq_det_share_if.sv
// Requester-side bus of the shared sequence-detector controller.
// The master modport is the requester pair and the slave modport is the controller.
interface seq_det_share_if #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4
);
    logic              req0;
    logic [WORD_W-1:0] word0;
    logic              req1;
    logic [WORD_W-1:0] word1;
    logic              gnt0;
    logic              gnt1;
    logic              busy;
    logic              done;
    logic              done_id;
    logic [CNT_W-1:0]  hit_cnt;

    modport master (
        output req0, word0, req1, word1,
        input  gnt0, gnt1, busy, done, done_id, hit_cnt
    );

    modport slave (
        input  req0, word0, req1, word1,
        output gnt0, gnt1, busy, done, done_id, hit_cnt
    );
endinterface

// File: rtl/seq_det_share_ctrl.sv
// Round-robin sharing of one bit-serial Mealy sequence detector between two requesters.
// Each captured word is shifted in MSB-first after a detector clear, and the y pulses are counted.
//
//   state | meaning
//   IDLE  | detector out of reset, waiting for req0/req1; arbitration happens here
//   CLR   | grant pulse to the winner, detector held in reset, counters cleared
//   SHIFT | WORD_W cycles driving shreg MSB onto det_xin while counting det_y
//   DONE  | done pulse, hit_cnt/done_id valid
module seq_det_share_ctrl #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    seq_det_share_if.slave   bus,
    output logic             det_xin,
    output logic             det_rst_n,
    input  logic             det_y
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLR   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_gnt;
    logic              winner;
    logic              any_req;
    logic [WORD_W-1:0] shreg;
    logic [IDX_W-1:0]  bit_idx;
    logic              bit_last;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  hit_cnt_q;
    logic              done_id_q;

    assign any_req  = bus.req0 | bus.req1;
    assign bit_last = (bit_idx == '0);

    // On a tie the requester that was not served last wins.
    always_comb begin
        winner = 1'b0;
        if (bus.req0 && bus.req1) begin
            winner = ~last_gnt;
        end else if (bus.req1) begin
            winner = 1'b1;
        end
    end

    always_comb begin
        cnt_inc = cnt;
        if (det_y && (cnt != '1)) begin
            cnt_inc = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = CLR;
            CLR:     state_nxt = SHIFT;
            SHIFT:   if (bit_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // bit_idx is a down-counter; its terminal count ends the SHIFT phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt  <= 1'b1;
            shreg     <= '0;
            bit_idx   <= '0;
            cnt       <= '0;
            hit_cnt_q <= '0;
            done_id_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        shreg    <= winner ? bus.word1 : bus.word0;
                        last_gnt <= winner;
                    end
                end
                CLR: begin
                    cnt     <= '0;
                    bit_idx <= IDX_W'(WORD_W - 1);
                end
                SHIFT: begin
                    shreg   <= shreg << 1;
                    cnt     <= cnt_inc;
                    bit_idx <= bit_idx - 1'b1;
                    if (bit_last) begin
                        hit_cnt_q <= cnt_inc;
                        done_id_q <= last_gnt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // det_rst_n also follows reset directly so the detector stays cleared until release.
    always_comb begin
        bus.gnt0    = (state == CLR) && !last_gnt;
        bus.gnt1    = (state == CLR) && last_gnt;
        bus.busy    = (state != IDLE);
        bus.done    = (state == DONE);
        bus.done_id = done_id_q;
        bus.hit_cnt = hit_cnt_q;
        det_xin     = (state == SHIFT) && shreg[WORD_W-1];
        det_rst_n   = !reset && (state != CLR);
    end

endmodule
